// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The master side issues start with operands; the slave side (the subtractor)
// returns busy/done and the registered result flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, zero, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, zero, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - borrow_in, one bit per clock, LSB first.
// A single full-subtractor cell is reused every RUN cycle; the partial
// difference is shifted in from the MSB side so that after WIDTH cycles it
// lines up as the finished result. Result outputs only change on completion
// (or reset), so partial values are never visible.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_subtractor_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One full-subtractor cell: returns {borrow_next, diff_bit}.
  function automatic logic [1:0] fsub_bit(input logic ai, input logic bi, input logic br);
    fsub_bit = {(~ai & bi) | (~(ai ^ bi) & br), ai ^ bi ^ br};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       cell_s;

  // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    br_d         = br_q;
    part_d       = part_q;
    cnt_d        = cnt_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    busy_d       = busy_q;
    done_d       = done_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    overflow_d   = overflow_q;
    cell_s       = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.borrow_in;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          part_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        cell_s = fsub_bit(a_sh_q[0], b_sh_q[0], br_q);
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_s[1];
        part_d = part_q >> 1;
        part_d[WIDTH-1] = cell_s[0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Last bit: publish the whole result in the same edge.
          state_d      = S_DONE;
          done_d       = 1'b1;
          diff_d       = part_d;
          borrow_out_d = cell_s[1];
          zero_d       = (part_d == '0);
          overflow_d   = (a_msb_q != b_msb_q) && (cell_s[0] != a_msb_q);
        end else begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      br_q         <= 1'b0;
      part_q       <= '0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      br_q         <= br_d;
      part_q       <= part_d;
      cnt_q        <= cnt_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = overflow_q;

endmodule
